// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 (optionally 8E1) UART receiver with a single-entry valid/ready output
//
// Purpose:
//   Samples the asynchronous UART_RXD line, recovers LSB-first 8-bit characters and
//   presents each one in a one-deep holding register with a valid/ready handshake.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frame, a PAR state samples the even-parity bit and PARITY_ERR is live
//   undefined -> 8N1 frame, no parity logic, PARITY_ERR is constant 0
//
// Ports:
//   CLOCK_50    in   1  system clock, single clock domain
//   RESET_N     in   1  asynchronous active-low reset
//   UART_RXD    in   1  serial line, idles high, asynchronous to CLOCK_50
//   RX_DATA     out  8  received byte, valid while RX_VALID=1
//   RX_VALID    out  1  byte available in the holding register
//   RX_READY    in   1  consumer accepts RX_DATA when RX_VALID=1 and RX_READY=1
//   FRAME_ERR   out  1  one-cycle pulse: stop bit sampled low
//   OVERRUN     out  1  one-cycle pulse: completed byte dropped, holding register full
//   PARITY_ERR  out  1  one-cycle pulse: even-parity check failed on a good frame

module uart_rx_8n1 #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       UART_RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       PARITY_ERR
);

    localparam int BIT_CLKS  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_CLKS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;
`endif

    // Two-flop synchronizer; both stages reset to the idle (high) line level
    logic r_rxd_meta;
    logic r_rxd_s;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= UART_RXD;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bit;
    logic             r_parity_err;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // Handshake frees the holding register; a byte completing in the same
            // cycle overrides this below and keeps RX_VALID high.
            if (r_rx_valid && RX_READY) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_s) begin
                        r_cnt   <= HALF_RELOAD;
                        r_state <= S_START;
                    end
                end

                // Mid-start-bit re-check rejects glitches shorter than half a bit
                S_START: begin
                    if (r_cnt == '0) begin
                        if (!r_rxd_s) begin
                            r_cnt     <= BIT_RELOAD;
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                // Right shift with MSB insert: first (LSB) bit ends up in bit 0
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {r_rxd_s, r_shift[7:1]};
                        r_cnt   <= BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PAR;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PAR: begin
                    if (r_cnt == '0) begin
                        r_par_bit <= r_rxd_s;
                        r_cnt     <= BIT_RELOAD;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_rxd_s) begin
                            if (!r_rx_valid || RX_READY) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= ^{r_shift, r_par_bit};
`endif
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                // Wait out a held-low line so it reports only one framing error
                S_BREAK: begin
                    if (r_rxd_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RX_DATA   = r_rx_data;
    assign RX_VALID  = r_rx_valid;
    assign FRAME_ERR = r_frame_err;
    assign OVERRUN   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = r_parity_err;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - scoreboard testbench for uart_rx_8n1 (BIT_CLKS=16, HALF_CLKS=8)

module tb_uart_rx_8n1;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // First low at cycle 0 -> RX_VALID / error pulses visible at this cycle
    localparam int LAT = 2 + 8 + (8 + P) * BIT + BIT + 1;

    localparam int K_FRAME  = 0;
    localparam int K_OVR    = 1;
    localparam int K_PARITY = 2;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       UART_RXD = 1'b1;
    logic       RX_READY = 1'b0;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       PARITY_ERR;

    uart_rx_8n1 #(
        .CLK_HZ(1600000),
        .BAUD  (100000)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .UART_RXD  (UART_RXD),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN),
        .PARITY_ERR(PARITY_ERR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         load_cyc;
    } byte_t;

    typedef struct {
        int kind;
        int at_cyc;
    } err_t;

    byte_t exp_bytes[$];
    err_t  exp_errs[$];

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic err_seen(input int kind);
        err_t e;
        if (exp_errs.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_err: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = exp_errs.pop_front();
            check("err_kind", kind, e.kind);
            check("err_cycle", cyc, e.at_cyc);
        end
    endtask

    // Monitor: compares each accepted byte and each error pulse against the scoreboard
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    int   load_cyc   = -1;

    always @(negedge CLOCK_50) begin
        byte_t b;
        if (!RESET_N) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (RX_VALID && (!prev_valid || prev_hs)) load_cyc = cyc;
            if (RX_VALID && RX_READY) begin
                if (exp_bytes.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: got 0x%0h at cycle %0d expected none", RX_DATA, cyc);
                end else begin
                    b = exp_bytes.pop_front();
                    check("rx_data", int'(RX_DATA), int'(b.data));
                    if (b.load_cyc >= 0) check("rx_valid_cycle", load_cyc, b.load_cyc);
                end
            end
            if (FRAME_ERR)  err_seen(K_FRAME);
            if (OVERRUN)    err_seen(K_OVR);
            if (PARITY_ERR) err_seen(K_PARITY);
            prev_valid = RX_VALID;
            prev_hs    = RX_VALID && RX_READY;
        end
    end

    task automatic align();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Must be called just after a rising edge; returns one frame later, same phase
    task automatic send_frame(input logic [7:0] d, input logic par);
        UART_RXD = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = d[i];
            wait_cycles(BIT);
        end
        if (P == 1) begin
            UART_RXD = par;
            wait_cycles(BIT);
        end
        UART_RXD = 1'b1;
        wait_cycles(BIT);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_bytes.push_back('{data: d, load_cyc: cyc + LAT});
        send_frame(d, ^d);
    endtask

    initial begin
        int k;
        int k2;

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        check("reset_rx_data", int'(RX_DATA), 0);
        check("reset_rx_valid", int'(RX_VALID), 0);
        check("reset_frame_err", int'(FRAME_ERR), 0);
        check("reset_overrun", int'(OVERRUN), 0);
        check("reset_parity_err", int'(PARITY_ERR), 0);
        align();
        RESET_N = 1'b1;
        wait_cycles(1000);
        check("idle_rx_valid", int'(RX_VALID), 0);
        check("idle_rx_data", int'(RX_DATA), 0);

        // Single byte with the consumer always ready
        RX_READY = 1'b1;
        align();
        send_good(8'hA5);
        wait_cycles(20);
        check("single_drained", exp_bytes.size(), 0);

        // Overrun: second back-to-back byte dropped while the first is held
        RX_READY = 1'b0;
        align();
        k = cyc;
        exp_bytes.push_back('{data: 8'h3C, load_cyc: k + LAT});
        send_frame(8'h3C, ^8'h3C);
        k2 = cyc;
        exp_errs.push_back('{kind: K_OVR, at_cyc: k2 + LAT});
        send_frame(8'hC3, ^8'hC3);
        wait_cycles(20);
        check("ovr_hold_valid", int'(RX_VALID), 1);
        check("ovr_hold_data", int'(RX_DATA), 8'h3C);
        RX_READY = 1'b1;
        wait_cycles(1);
        RX_READY = 1'b0;
        wait_cycles(1);
        check("ovr_cleared_valid", int'(RX_VALID), 0);

        // False start glitch, then an all-zero byte
        RX_READY = 1'b1;
        align();
        UART_RXD = 1'b0;
        wait_cycles(5);
        UART_RXD = 1'b1;
        wait_cycles(40);
        check("glitch_no_valid", int'(RX_VALID), 0);
        send_good(8'h00);
        wait_cycles(20);

        // Break: 400 cycles low gives one framing error, then 0x55
        align();
        k = cyc;
        exp_errs.push_back('{kind: K_FRAME, at_cyc: k + LAT});
        UART_RXD = 1'b0;
        wait_cycles(400);
        UART_RXD = 1'b1;
        wait_cycles(30);
        send_good(8'h55);
        wait_cycles(20);

        // Handshake in the same cycle a new byte completes: no overrun
        RX_READY = 1'b0;
        align();
        send_good(8'h81);
        k2 = cyc;
        exp_bytes.push_back('{data: 8'h18, load_cyc: k2 + LAT});
        fork
            send_frame(8'h18, ^8'h18);
            begin
                wait_cycles(LAT - 1);
                RX_READY = 1'b1;
                wait_cycles(1);
                RX_READY = 1'b0;
            end
        join
        wait_cycles(10);
        check("simul_valid", int'(RX_VALID), 1);
        check("simul_data", int'(RX_DATA), 8'h18);
        RX_READY = 1'b1;
        wait_cycles(5);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so a correct parity bit is 1
        align();
        exp_bytes.push_back('{data: 8'h07, load_cyc: cyc + LAT});
        send_frame(8'h07, 1'b1);
        k = cyc;
        exp_bytes.push_back('{data: 8'h07, load_cyc: k + LAT});
        exp_errs.push_back('{kind: K_PARITY, at_cyc: k + LAT});
        send_frame(8'h07, 1'b0);
        wait_cycles(20);
`endif

        // Drain, bounded
        for (int i = 0; i < 200 && (exp_bytes.size() != 0 || exp_errs.size() != 0); i++) begin
            wait_cycles(1);
        end
        check("bytes_outstanding", exp_bytes.size(), 0);
        check("errs_outstanding", exp_errs.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Asynchronous serial receiver that samples UART_RXD, recovers 8-bit characters (8N1, LSB first), and presents each byte on a single-entry valid/ready output register. It is the receive-side counterpart of the board's UART_TXD transmit path. It sits between the UART_RXD pin on the starter-kit top level and any on-chip consumer, such as the LED/HEX debug logic or a command parser.

## Interface
Parameters:
- CLK_HZ, 50000000: frequency of CLOCK_50 in Hz.
- BAUD, 115200: line rate in bits per second.
- Derived, not overridable:
  - BIT_CLKS = (CLK_HZ + BAUD/2) / BAUD, which is 434 at the defaults.
  - HALF_CLKS = BIT_CLKS / 2, truncated.

Ports (reset is asynchronous, active-low):
- CLOCK_50  in  1  system clock; all logic runs in this one domain.
- RESET_N  in  1  asynchronous active-low reset.
- UART_RXD  in  1  serial line; idles high; asynchronous to CLOCK_50.
- RX_DATA  out  8  received byte; valid while RX_VALID=1.
- RX_VALID  out  1  byte available in the holding register.
- RX_READY  in  1  consumer accepts RX_DATA when RX_VALID=1 and RX_READY=1.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- PARITY_ERR  out  1  one-cycle pulse; tied to 0 when UART_RX_PARITY_EN is undefined.

## Operation
- Input conditioning:
  - UART_RXD passes through a 2-flop synchronizer, giving rxd_s.
  - Both flops reset to 1.
- State machine: IDLE, START, DATA, PAR (only when parity is enabled), STOP, BREAK.
  - IDLE: when rxd_s=0, load bit counter with HALF_CLKS-1 and go to START.
  - START: at counter 0, re-sample rxd_s.
    - 0: load BIT_CLKS-1, clear bit index, go to DATA.
    - 1: false start; return to IDLE with no output and no error.
  - DATA: each time the counter reaches 0, sample rxd_s into the shift register, MSB-in with a right shift so the LSB arrives first, and reload BIT_CLKS-1.
    - After the 8th sample, go to PAR if enabled, else STOP.
  - PAR: at counter 0, sample the parity bit, reload BIT_CLKS-1, go to STOP.
  - STOP: at counter 0, sample rxd_s.
    - 1: the frame is good; go to IDLE.
    - 0: pulse FRAME_ERR, discard the byte, go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE. A held-low line therefore produces exactly one FRAME_ERR.
- Counter: width is $clog2(BIT_CLKS); it counts down and reloads as stated above.
- Output register, on a good frame:
  - RX_VALID=0, or RX_VALID=1 and RX_READY=1 in the same cycle: load RX_DATA and set RX_VALID=1.
  - RX_VALID=1 and RX_READY=0: the new byte is dropped, RX_DATA is unchanged, and OVERRUN pulses.
  - A handshake with no new byte clears RX_VALID.
- A good frame with a parity mismatch is still delivered and also pulses PARITY_ERR.
- Reset asserted mid-frame aborts immediately:
  - State returns to IDLE and the shift register clears.
  - The byte in progress is lost.
  - After RESET_N rises, a line that is already low causes entry to START. A partial frame can therefore produce a FRAME_ERR; this is accepted behaviour.

## Timing
- Reset values: RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0, state=IDLE.
- Latency: the first low of UART_RXD counts as cycle 0.
  - rxd_s falls at cycle 2.
  - The stop-bit sample occurs at cycle 2 + HALF_CLKS + (8 + P) * BIT_CLKS + BIT_CLKS, where P is 1 with parity and 0 without.
  - RX_VALID rises on the following cycle.
  - Error pulses occur in that same cycle.
- RX_DATA is stable from RX_VALID rising until the accepting handshake cycle.
- Back-to-back frames: a start edge may be detected on the cycle immediately after leaving STOP.
- Throughput: one byte per (10 + P) * BIT_CLKS cycles.
- Tolerated baud mismatch: ±2% at the defaults.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PAR state is present and the frame is 8E1 (even parity). PARITY_ERR pulses when the XOR of the 8 data bits and the parity bit equals 1.
  - Undefined: the frame is 8N1, the PAR state and parity logic are absent, and PARITY_ERR is constant 0.

## Test plan
All scenarios use CLK_HZ=1600000 and BAUD=100000, giving BIT_CLKS=16 and HALF_CLKS=8.
- Reset check: hold RESET_N=0, drive UART_RXD=1, release reset → all outputs 0 and no activity for 1000 cycles.
- Single byte: send 0xA5 (8N1) with RX_READY=1 → RX_VALID pulses exactly once, on cycle 2+8+144+1=155, with RX_DATA=0xA5 and no error pulses.
- Overrun: hold RX_READY=0 and send 0x3C then 0xC3 back-to-back → RX_DATA stays 0x3C and RX_VALID stays 1; OVERRUN pulses once at the end of the second frame. Raising RX_READY for one cycle then clears RX_VALID.
- False start: apply a 5-cycle low glitch on UART_RXD → no RX_VALID and no FRAME_ERR. A following 0x00 byte is received correctly.
- Break and simultaneous handshake:
  - Hold UART_RXD low for 400 cycles → FRAME_ERR pulses exactly once; after the line returns high, the next byte 0x55 is received.
  - Assert RX_READY on the same cycle a new byte completes while RX_VALID=1 → the new byte is loaded and RX_VALID stays 1 with no OVERRUN.
- Parity, with UART_RX_PARITY_EN defined:
  - Send 0x07 with parity bit 1 → RX_DATA=0x07 and no PARITY_ERR.
  - Send 0x07 with parity bit 0 → RX_DATA=0x07 and PARITY_ERR pulses in the same cycle RX_VALID rises.
